// File: rtl/training_sequencer.sv
// Replays a small (x1, x2, target) dataset for NUM_EPOCHS epochs with valid_o held high for the whole run.
// Optional macro SHUFFLE_EN permutes each epoch with an LFSR-derived XOR key.
module training_sequencer #(
  parameter int          SIGN        = 1,
  parameter int          Q_M         = 15,
  parameter int          Q_N         = 16,
  parameter int          NUM_SAMPLES = 4,
  parameter int          NUM_EPOCHS  = 100,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  localparam int         W           = SIGN + Q_M + Q_N,
  localparam int         ADDR_W      = $clog2(NUM_SAMPLES),
  localparam int         EPOCH_W     = $clog2(NUM_EPOCHS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [W-1:0]       wr_x1_i,
  input  logic [W-1:0]       wr_x2_i,
  input  logic [W-1:0]       wr_y_i,
  output logic [W-1:0]       train_x1_o,
  output logic [W-1:0]       train_x2_o,
  output logic [W-1:0]       train_out_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  sample_idx_o,
  output logic [EPOCH_W-1:0] epoch_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [W-1:0]       ONE_C      = {{(W-1){1'b0}}, 1'b1} << Q_N;
  localparam logic [ADDR_W-1:0]  IDX_LAST_C = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] EP_LAST_C  = EPOCH_W'(NUM_EPOCHS - 1);
  localparam logic [EPOCH_W-1:0] EP_END_C   = EPOCH_W'(NUM_EPOCHS);

  // AND truth table in fixed point: col 0 = x1, 1 = x2, 2 = target
  function automatic logic [W-1:0] and_entry(input int idx, input int col);
    logic hit;
    case (col)
      0:       hit = (idx == 2) || (idx == 3);
      1:       hit = (idx == 1) || (idx == 3);
      2:       hit = (idx == 3);
      default: hit = 1'b0;
    endcase
    return hit ? ONE_C : {W{1'b0}};
  endfunction

  state_t              state_r, state_nxt_s;
  logic [W-1:0]        mem_x1_r [NUM_SAMPLES];
  logic [W-1:0]        mem_x2_r [NUM_SAMPLES];
  logic [W-1:0]        mem_y_r  [NUM_SAMPLES];
  logic [ADDR_W-1:0]   idx_r, idx_nxt_s, addr_s;
  logic [EPOCH_W-1:0]  epoch_r, epoch_nxt_s;
  logic [W-1:0]        x1_r, x2_r, y_r;
  logic                valid_r, busy_r, done_r;
  logic                load_s, wr_s, epoch_start_s;

  // Next-state, sample sequencing and dataset write qualification
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    epoch_nxt_s   = epoch_r;
    load_s        = 1'b0;
    wr_s          = 1'b0;
    epoch_start_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (wr_en_i) begin
          wr_s = 1'b1;
        end else if (start_i) begin
          state_nxt_s   = ST_RUN;
          idx_nxt_s     = {ADDR_W{1'b0}};
          epoch_nxt_s   = {EPOCH_W{1'b0}};
          load_s        = 1'b1;
          epoch_start_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_nxt_s = ST_IDLE;
        end else if ((idx_r == IDX_LAST_C) && (epoch_r == EP_LAST_C)) begin
          state_nxt_s = ST_DONE;
          epoch_nxt_s = EP_END_C;
        end else begin
          load_s    = 1'b1;
          idx_nxt_s = idx_r + ADDR_W'(1);
          if (idx_r == IDX_LAST_C) begin
            epoch_nxt_s   = epoch_r + EPOCH_W'(1);
            epoch_start_s = 1'b1;
          end else begin
            epoch_start_s = 1'b0;
          end
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef SHUFFLE_EN
  logic [7:0]        lfsr_r, lfsr_nxt_s;
  logic [ADDR_W-1:0] key_r, key_s;

  // LFSR step and per-epoch key selection
  always_comb begin
    lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    if (epoch_start_s) begin
      key_s = lfsr_nxt_s[ADDR_W-1:0];
    end else begin
      key_s = key_r;
    end
    addr_s = idx_nxt_s ^ key_s;
  end

  // LFSR and key registers, advanced once per epoch
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_r <= LFSR_SEED;
      key_r  <= {ADDR_W{1'b0}};
    end else if (epoch_start_s) begin
      lfsr_r <= lfsr_nxt_s;
      key_r  <= key_s;
    end
  end
`else
  assign addr_s = idx_nxt_s;
`endif

  // Dataset storage, reverting to the AND table on reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        mem_x1_r[i] <= and_entry(i, 0);
        mem_x2_r[i] <= and_entry(i, 1);
        mem_y_r[i]  <= and_entry(i, 2);
      end
    end else if (wr_s) begin
      mem_x1_r[wr_addr_i] <= wr_x1_i;
      mem_x2_r[wr_addr_i] <= wr_x2_i;
      mem_y_r[wr_addr_i]  <= wr_y_i;
    end
  end

  // State and registered outputs; data holds whenever no sample is loaded
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
      epoch_r <= {EPOCH_W{1'b0}};
      x1_r    <= {W{1'b0}};
      x2_r    <= {W{1'b0}};
      y_r     <= {W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      epoch_r <= epoch_nxt_s;
      valid_r <= (state_nxt_s == ST_RUN);
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      if (load_s) begin
        x1_r <= mem_x1_r[addr_s];
        x2_r <= mem_x2_r[addr_s];
        y_r  <= mem_y_r[addr_s];
      end
    end
  end

  assign train_x1_o   = x1_r;
  assign train_x2_o   = x2_r;
  assign train_out_o  = y_r;
  assign valid_o      = valid_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign sample_idx_o = idx_r;
  assign epoch_o      = epoch_r;

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench for training_sequencer with NUM_EPOCHS=2; honours SHUFFLE_EN if defined.
module tb_training_sequencer;

  localparam int          W    = 32;
  localparam int          AW   = 2;
  localparam int          EW   = 2;
  localparam int          NS   = 4;
  localparam int          NE   = 2;
  localparam logic [7:0]  SEED = 8'hA5;
  localparam logic [31:0] ONE  = 32'h0001_0000;

  logic          clk_i = 1'b0;
  logic          reset_i, start_i, abort_i, wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [W-1:0]  wr_x1_i, wr_x2_i, wr_y_i;
  logic [W-1:0]  train_x1_o, train_x2_o, train_out_o;
  logic          valid_o, busy_o, done_o;
  logic [AW-1:0] sample_idx_o;
  logic [EW-1:0] epoch_o;

  training_sequencer #(.NUM_EPOCHS(NE), .LFSR_SEED(SEED)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_x1_i(wr_x1_i), .wr_x2_i(wr_x2_i),
    .wr_y_i(wr_y_i), .train_x1_o(train_x1_o), .train_x2_o(train_x2_o),
    .train_out_o(train_out_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o),
    .sample_idx_o(sample_idx_o), .epoch_o(epoch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0]  x1;
    logic [W-1:0]  x2;
    logic [W-1:0]  y;
    logic [AW-1:0] idx;
    logic [EW-1:0] ep;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_x1 [NS];
  logic [W-1:0] m_x2 [NS];
  logic [W-1:0] m_y  [NS];
  logic [7:0]   sb_lfsr;
  int           checks = 0;
  int           failures = 0;
  int           valid_cnt = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NS; i++) begin
      m_x1[i] = (i == 2 || i == 3) ? ONE : 32'h0;
      m_x2[i] = (i == 1 || i == 3) ? ONE : 32'h0;
      m_y[i]  = (i == 3) ? ONE : 32'h0;
    end
    sb_lfsr = SEED;
  endtask

  task automatic push_run();
    logic [AW-1:0] key;
    logic [AW-1:0] a;
    exp_t e;
    for (int ep = 0; ep < NE; ep++) begin
      key = '0;
`ifdef SHUFFLE_EN
      sb_lfsr = lfsr_step(sb_lfsr);
      key = sb_lfsr[AW-1:0];
`endif
      for (int i = 0; i < NS; i++) begin
        a    = AW'(i) ^ key;
        e.x1 = m_x1[a];
        e.x2 = m_x2[a];
        e.y  = m_y[a];
        e.idx = AW'(i);
        e.ep  = EW'(ep);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] x1,
                          input logic [W-1:0] x2, input logic [W-1:0] y);
    wr_en_i = 1'b1; wr_addr_i = a; wr_x1_i = x1; wr_x2_i = x2; wr_y_i = y;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    push_run();
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq("done_reached", {31'h0, done_o}, 32'h1);
  endtask

  // Scoreboard: every valid cycle pops one expected sample
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (valid_o === 1'b1) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'h1);
      end else begin
        e = sb_q.pop_front();
        check_eq("x1", train_x1_o, e.x1);
        check_eq("x2", train_x2_o, e.x2);
        check_eq("y", train_out_o, e.y);
        check_eq("idx", 32'(sample_idx_o), 32'(e.idx));
        check_eq("epoch", 32'(epoch_o), 32'(e.ep));
        check_eq("busy_run", {31'h0, busy_o}, 32'h1);
      end
    end
  end

  initial begin
    logic [7:0] saved_lfsr;
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; wr_en_i = 1'b0;
    wr_addr_i = '0; wr_x1_i = '0; wr_x2_i = '0; wr_y_i = '0;
    reset_model();
    tick(); tick();
    check_eq("rst_valid", {31'h0, valid_o}, 32'h0);
    check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
    check_eq("rst_done", {31'h0, done_o}, 32'h0);
    check_eq("rst_x1", train_x1_o, 32'h0);
    check_eq("rst_y", train_out_o, 32'h0);
    check_eq("rst_epoch", 32'(epoch_o), 32'h0);
    reset_i = 1'b0;
    tick();

    // Full AND-table run
    valid_cnt = 0;
    start_run();
    wait_done();
    check_eq("done_epoch", 32'(epoch_o), 32'(NE));
    check_eq("done_valid", {31'h0, valid_o}, 32'h0);
    check_eq("done_busy", {31'h0, busy_o}, 32'h0);
    check_eq("valid_cycles", 32'(valid_cnt), 32'(NS * NE));
    check_eq("sb_drained1", 32'(sb_q.size()), 32'h0);
`ifndef SHUFFLE_EN
    check_eq("done_hold_y", train_out_o, ONE);
`endif
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("abort_in_done", {31'h0, done_o}, 32'h1);

    // XOR-style edit in DONE, then a write during RUN that must be ignored
    do_write(2'd3, ONE, ONE, 32'h0);
    m_x1[3] = ONE; m_x2[3] = ONE; m_y[3] = 32'h0;
    start_run();
    check_eq("done_clears", {31'h0, done_o}, 32'h0);
    do_write(2'd0, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000);
    wait_done();
    check_eq("sb_drained2", 32'(sb_q.size()), 32'h0);

    // Abort after three presented samples
    saved_lfsr = sb_lfsr;
    start_run();
    tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("abort_valid", {31'h0, valid_o}, 32'h0);
    check_eq("abort_busy", {31'h0, busy_o}, 32'h0);
    check_eq("abort_done", {31'h0, done_o}, 32'h0);
`ifndef SHUFFLE_EN
    check_eq("abort_hold_x1", train_x1_o, m_x1[2]);
`endif
    sb_q.delete();
    sb_lfsr = lfsr_step(saved_lfsr);

    // start and write in the same IDLE cycle: write wins
    start_i = 1'b1;
    do_write(2'd1, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    start_i = 1'b0;
    m_x1[1] = 32'h0002_0000; m_x2[1] = 32'h0003_0000; m_y[1] = 32'h0004_0000;
    check_eq("startwr_busy", {31'h0, busy_o}, 32'h0);
    check_eq("startwr_valid", {31'h0, valid_o}, 32'h0);
    start_run();
    wait_done();
    check_eq("sb_drained3", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset mid-epoch
    start_run();
    tick(); tick();
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check_eq("arst_valid", {31'h0, valid_o}, 32'h0);
    check_eq("arst_busy", {31'h0, busy_o}, 32'h0);
    check_eq("arst_x1", train_x1_o, 32'h0);
    check_eq("arst_x2", train_x2_o, 32'h0);
    check_eq("arst_idx", 32'(sample_idx_o), 32'h0);
    sb_q.delete();
    reset_model();
    tick();
    reset_i = 1'b0;
    tick();
    start_run();
    wait_done();
    check_eq("sb_drained4", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
